// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared types and constants for the load/store request engine.
//   funct3 codes for RV32I loads/stores, FSM state encoding, and write-mask width.
package ysyx_23060240_lsu_pkg;

  localparam int unsigned WMASK_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// Combinational lane logic for the LSU request engine.
//   Store path: st_funct3_i/st_is_store_i/st_off_i/st_wdata_i -> st_wmask_o, st_wdata_o, misalign_o
//   Load path : ld_funct3_i/ld_off_i/ld_rdata_i -> ld_data_o (sign/zero extended)
// Optional: LSU_MISALIGN_CHECK_EN enables misalign_o; otherwise it is tied to 0 and
// misaligned accesses fall back to the naturally aligned lane.
module ysyx_23060240_lsu_align
  import ysyx_23060240_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]         st_funct3_i,
  input  logic               st_is_store_i,
  input  logic [1:0]         st_off_i,
  input  logic [DATA_W-1:0]  st_wdata_i,
  output logic [WMASK_W-1:0] st_wmask_o,
  output logic [DATA_W-1:0]  st_wdata_o,
  output logic               misalign_o,
  input  logic [2:0]         ld_funct3_i,
  input  logic [1:0]         ld_off_i,
  input  logic [DATA_W-1:0]  ld_rdata_i,
  output logic [DATA_W-1:0]  ld_data_o
);

  logic        st_word, st_half;
  logic [1:0]  st_lane;
  logic        ld_word, ld_half;
  logic [1:0]  ld_lane;
  logic [DATA_W-1:0] ld_shift;

  // Store lanes; reserved store codes (1xx, 011) act as word accesses.
  always_comb begin
    st_word = st_funct3_i[1] | (st_is_store_i & st_funct3_i[2]);
    st_half = !st_word && st_funct3_i[0];
    st_lane = st_word ? 2'b00 : (st_half ? {st_off_i[1], 1'b0} : st_off_i);
    if (st_word) begin
      st_wmask_o = WMASK_W'(4'hF);
      st_wdata_o = st_wdata_i;
    end else if (st_half) begin
      st_wmask_o = WMASK_W'(4'h3) << st_lane;
      st_wdata_o = DATA_W'(st_wdata_i[15:0]) << {st_lane, 3'b000};
    end else begin
      st_wmask_o = WMASK_W'(4'h1) << st_lane;
      st_wdata_o = DATA_W'(st_wdata_i[7:0]) << {st_lane, 3'b000};
    end
  end

  // Load extraction; funct3[2] selects zero extension, reserved codes read a word.
  always_comb begin
    ld_word  = ld_funct3_i[1];
    ld_half  = !ld_word && ld_funct3_i[0];
    ld_lane  = ld_word ? 2'b00 : (ld_half ? {ld_off_i[1], 1'b0} : ld_off_i);
    ld_shift = ld_rdata_i >> {ld_lane, 3'b000};
    if (ld_word) begin
      ld_data_o = ld_shift;
    end else if (ld_half) begin
      ld_data_o = ld_funct3_i[2] ? DATA_W'(ld_shift[15:0])
                                 : {{(DATA_W-16){ld_shift[15]}}, ld_shift[15:0]};
    end else begin
      ld_data_o = ld_funct3_i[2] ? DATA_W'(ld_shift[7:0])
                                 : {{(DATA_W-8){ld_shift[7]}}, ld_shift[7:0]};
    end
  end

  // Misalignment / reserved-code detection on the request being accepted.
  always_comb begin
    misalign_o = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (st_funct3_i)
      F3_LB:   misalign_o = 1'b0;
      F3_LH:   misalign_o = st_off_i[0];
      F3_LW:   misalign_o = (st_off_i != 2'b00);
      F3_LBU:  misalign_o = st_is_store_i;
      F3_LHU:  misalign_o = st_is_store_i | st_off_i[0];
      default: misalign_o = 1'b1;
    endcase
`endif
  end

endmodule

// File: rtl/ysyx_23060240_lsu_req.sv
// Load/store request engine between EXU and the LSU SRAM model.
//   EXU side : in_valid/in_ready handshake, in_ren/in_wen/in_funct3/in_addr/in_wdata
//   WBU side : out_valid/out_ready handshake, out_rdata/out_err
//   SRAM side: mem_raddr/mem_waddr/mem_r_en/mem_w_en/mem_wmask/mem_wdata, mem_rdata (1-cycle latency)
// Optional: LSU_MISALIGN_CHECK_EN turns misaligned/reserved accesses into error responses.
module ysyx_23060240_lsu_req
  import ysyx_23060240_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_ren,
  input  logic               in_wen,
  input  logic [2:0]         in_funct3,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_rdata,
  output logic               out_err,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic               mem_r_en,
  output logic               mem_w_en,
  output logic [WMASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_rdata_q, out_rdata_d;
  logic                out_err_q, out_err_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic                r_en_q, r_en_d, w_en_q, w_en_d;
  logic [WMASK_W-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;

  logic [WMASK_W-1:0]  st_wmask;
  logic [DATA_W-1:0]   st_wdata, ld_data;
  logic                misalign;
  logic [ADDR_W-1:0]   word_addr;

  assign word_addr = {in_addr[ADDR_W-1:2], 2'b00};

  ysyx_23060240_lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_funct3_i  (in_funct3),
    .st_is_store_i(in_wen),
    .st_off_i     (in_addr[1:0]),
    .st_wdata_i   (in_wdata),
    .st_wmask_o   (st_wmask),
    .st_wdata_o   (st_wdata),
    .misalign_o   (misalign),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (mem_rdata),
    .ld_data_o    (ld_data)
  );

  // Next-state and next-output logic; memory strobes and buses default to 0.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    raddr_d     = '0;
    waddr_d     = '0;
    r_en_d      = 1'b0;
    w_en_d      = 1'b0;
    wmask_d     = '0;
    wdata_d     = '0;
    off_d       = off_q;
    funct3_d    = funct3_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          off_d       = in_addr[1:0];
          funct3_d    = in_funct3;
          out_rdata_d = '0;
          out_err_d   = 1'b0;
          if (misalign && (in_ren || in_wen)) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
          end else if (in_wen) begin
            state_d = S_WR;
            w_en_d  = 1'b1;
            waddr_d = word_addr;
            wmask_d = st_wmask;
            wdata_d = st_wdata;
          end else if (in_ren) begin
            state_d = S_RD;
            r_en_d  = 1'b1;
            raddr_d = word_addr;
          end else begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        // SRAM data is valid this cycle (one cycle after the read strobe).
        out_rdata_d = ld_data;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_WR: begin
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset clears strobes asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      r_en_q      <= r_en_d;
      w_en_q      <= w_en_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_r_en  = r_en_q;
  assign mem_w_en  = w_en_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;

endmodule
